// File: rtl/conv1_line_buffer.sv
// Two-row line buffer for conv layer 1: turns a raster pixel stream
// into vertically aligned 3-pixel columns for the window shift registers.
module conv1_line_buffer #(
  parameter  int DW    = 8,
  parameter  int IMG_W = 28,
  parameter  int IMG_H = 28,
  localparam int CW    = $clog2(IMG_W),
  localparam int RW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_en,
  output logic [DW-1:0] out_row0,
  output logic [DW-1:0] out_row1,
  output logic [DW-1:0] out_row2,
  output logic          out_win_valid,
  output logic [CW-1:0] out_col,
  output logic [RW-1:0] out_row,
  output logic          frame_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [DW-1:0] r_lb0 [IMG_W];
  logic [DW-1:0] r_lb1 [IMG_W];

  logic w_acc;
  logic w_col_last;
  logic w_last;

  assign in_ready   = (r_state == S_RUN);
  assign w_acc      = in_ready && in_valid;
  assign w_col_last = (r_col == CW'(IMG_W - 1));
  assign w_last     = w_col_last && (r_row == RW'(IMG_H - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_acc && w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // RAM is left uncleared; top-row padding masks any stale contents
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb0[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_en        <= 1'b0;
      out_row0      <= '0;
      out_row1      <= '0;
      out_row2      <= '0;
      out_win_valid <= 1'b0;
      out_col       <= '0;
      out_row       <= '0;
      frame_done    <= 1'b0;
    end else begin
      out_en     <= w_acc;
      frame_done <= w_acc && w_last;
      if (w_acc) begin
        out_row0      <= (r_row >= RW'(2)) ? r_lb0[r_col] : '0;
        out_row1      <= (r_row >= RW'(1)) ? r_lb1[r_col] : '0;
        out_row2      <= in_data;
        out_win_valid <= (r_row >= RW'(2)) && (r_col >= CW'(2));
        out_col       <= r_col;
        out_row       <= r_row;
      end
    end
  end

endmodule

// File: tb/tb_conv1_line_buffer.sv
// Bench for conv1_line_buffer: directed frames plus randomized
// frames against a frame-array reference model.
module tb_conv1_line_buffer;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  logic          clk;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_en;
  logic [DW-1:0] out_row0;
  logic [DW-1:0] out_row1;
  logic [DW-1:0] out_row2;
  logic          out_win_valid;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;
  logic          frame_done;

  conv1_line_buffer #(
    .DW(DW),
    .IMG_W(W),
    .IMG_H(H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_en(out_en),
    .out_row0(out_row0),
    .out_row1(out_row1),
    .out_row2(out_row2),
    .out_win_valid(out_win_valid),
    .out_col(out_col),
    .out_row(out_row),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // phase: 0 idle, 1 run, 2 done; k = pixels accepted this frame
  int phase = 0;
  int k     = 0;
  logic [DW-1:0] fr [N];
  logic [DW-1:0] e0, e1, e2;
  int  ecol, erow;
  logic ewin;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input logic en, input logic fd);
    chk("out_en", 32'(out_en), 32'(en));
    chk("frame_done", 32'(frame_done), 32'(fd));
    chk("out_row0", 32'(out_row0), 32'(e0));
    chk("out_row1", 32'(out_row1), 32'(e1));
    chk("out_row2", 32'(out_row2), 32'(e2));
    chk("out_col", 32'(out_col), 32'(ecol));
    chk("out_row", 32'(out_row), 32'(erow));
    chk("win_valid", 32'(out_win_valid), 32'(ewin));
  endtask

  task automatic cyc(input logic v, input logic [DW-1:0] d,
                     input logic st);
    logic acc;
    logic last;
    start    = st;
    in_valid = v;
    in_data  = d;
    #1;
    chk("in_ready", 32'(in_ready), 32'(phase == 1));
    acc  = v && (phase == 1);
    last = acc && (k == N - 1);
    if (acc) begin
      fr[k] = d;
      erow  = k / W;
      ecol  = k % W;
      e2    = d;
      e1    = (erow >= 1) ? fr[k - W] : '0;
      e0    = (erow >= 2) ? fr[k - 2 * W] : '0;
      ewin  = (erow >= 2) && (ecol >= 2);
    end
    @(posedge clk);
    #1;
    check_outs(acc, last);
    case (phase)
      0: if (st) begin
        phase = 1;
        k     = 0;
      end
      1: if (acc) begin
        if (last) phase = 2;
        k++;
      end
      default: phase = 0;
    endcase
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    phase = 0;
    k     = 0;
    e0    = '0;
    e1    = '0;
    e2    = '0;
    ecol  = 0;
    erow  = 0;
    ewin  = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    check_outs(1'b0, 1'b0);
  endtask

  // mode 0: 1..N, no stalls; 1: random data/stalls/starts;
  // 2: 1..N with in_valid toggling and stray start pulses
  task automatic frame(input int mode, input int abort_k);
    int  g;
    logic v;
    logic st;
    logic [DW-1:0] d;
    g = 0;
    cyc(1'b0, '0, 1'b1);
    while (phase != 0 && g < 200) begin
      if (abort_k >= 0 && k == abort_k) begin
        do_reset();
        return;
      end
      case (mode)
        1: begin
          v  = ($urandom_range(0, 3) != 0);
          d  = DW'($urandom);
          st = ($urandom_range(0, 4) == 0);
        end
        2: begin
          v  = (g % 2 == 0);
          d  = DW'(k + 1);
          st = (g == 3) || (phase == 2);
        end
        default: begin
          v  = 1'b1;
          d  = DW'(k + 1);
          st = 1'b0;
        end
      endcase
      cyc(v, d, st);
      g++;
    end
    if (g >= 200) begin
      total++;
      bad++;
      $error("FAIL frame_timeout observed=%0d expected=<200", g);
    end
    cyc(1'b1, 8'hAA, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    @(posedge clk);
    #1;
    do_reset();
    frame(0, -1);
    frame(2, -1);
    frame(0, 6);
    cyc(1'b1, 8'h55, 1'b0);
    frame(0, -1);
    for (int i = 0; i < 6; i++) begin
      frame(1, -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
